// File: rtl/lifo_stack_pkg.sv
// Shared types for the LIFO stack: command encoding, FSM states and default geometry.
package lifo_pkg;

    localparam int LIFO_ADDR_BITS_DEF = 3;
    localparam int LIFO_WORD_BITS_DEF = 8;

    typedef enum logic [1:0] {
        NOP     = 2'b00,
        PUSH    = 2'b01,
        POP     = 2'b10,
        REPLACE = 2'b11
    } t_lifo_cmd;

    typedef enum logic [2:0] {
        Idle,
        Push,
        Pop,
        Replace,
        Refresh
    } t_lifo_state;

endpackage

// File: rtl/lifo_stack_if.sv
// Command/status bundle between a stack user (master) and lifo_stack (slave).
interface lifo_stack_if #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8
);
    logic [1:0]           in_cmd;
    logic [WORD_BITS-1:0] in_data;
    logic [WORD_BITS-1:0] out_top;
    logic [ADDR_BITS:0]   out_count;
    logic                 out_empty;
    logic                 out_full;
    logic                 out_ready;
    logic                 out_err;

    modport master (
        output in_cmd, in_data,
        input  out_top, out_count, out_empty, out_full, out_ready, out_err
    );

    modport slave (
        input  in_cmd, in_data,
        output out_top, out_count, out_empty, out_full, out_ready, out_err
    );
endinterface

// File: rtl/lifo_stack_mem.sv
// Stack storage: synchronous write port, asynchronous read port.
module stack_mem #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8
) (
    input  logic                 in_clk,
    input  logic                 in_we,
    input  logic [ADDR_BITS-1:0] in_waddr,
    input  logic [WORD_BITS-1:0] in_wdata,
    input  logic [ADDR_BITS-1:0] in_raddr,
    output logic [WORD_BITS-1:0] out_rdata
);
    localparam int DEPTH = 2**ADDR_BITS;

    logic [WORD_BITS-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; a word is only ever read after a push wrote it,
    // and leaving it out lets the array map onto plain RAM/register-file cells.
    always_ff @(posedge in_clk) begin
        if (in_we) begin
            r_mem[in_waddr] <= in_wdata;
        end
    end

    assign out_rdata = r_mem[in_raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with ready handshake, registered top word and replace-top command.
// Define LIFO_STACK_ERR_EN to build the sticky illegal-command flag.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int ADDR_BITS = LIFO_ADDR_BITS_DEF,
    parameter int WORD_BITS = LIFO_WORD_BITS_DEF
) (
    input  logic         in_clk,
    input  logic         in_rst,
    lifo_stack_if.slave  bus
);
    localparam int                 DEPTH   = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] C_ONE   = 1;
    localparam logic [ADDR_BITS:0] C_FULL  = DEPTH[ADDR_BITS:0];

    t_lifo_state          r_state;
    logic [ADDR_BITS:0]   r_count;
    logic [WORD_BITS-1:0] r_buf;
    logic [WORD_BITS-1:0] r_top;

    t_lifo_state          w_state_next;
    logic [ADDR_BITS:0]   w_count_next;
    logic [ADDR_BITS:0]   w_count_m1;
    logic [WORD_BITS-1:0] w_buf_next;
    logic [WORD_BITS-1:0] w_top_next;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_waddr;
    logic [WORD_BITS-1:0] w_rdata;
    logic                 w_empty;
    logic                 w_full;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_FULL);
    assign w_count_m1 = r_count - C_ONE;

    // Reset must squash a write scheduled by the Push/Replace state on the same edge.
    stack_mem #(
        .ADDR_BITS (ADDR_BITS),
        .WORD_BITS (WORD_BITS)
    ) u_mem (
        .in_clk    (in_clk),
        .in_we     (w_we && !in_rst),
        .in_waddr  (w_waddr),
        .in_wdata  (r_buf),
        .in_raddr  (w_count_m1[ADDR_BITS-1:0]),
        .out_rdata (w_rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_buf_next   = r_buf;
        w_top_next   = r_top;
        w_we         = 1'b0;
        w_waddr      = r_count[ADDR_BITS-1:0];
        case (r_state)
            Idle: begin
                case (t_lifo_cmd'(bus.in_cmd))
                    PUSH: if (!w_full) begin
                        w_buf_next   = bus.in_data;
                        w_state_next = Push;
                    end
                    POP: if (!w_empty) begin
                        w_state_next = Pop;
                    end
                    REPLACE: if (!w_empty) begin
                        w_buf_next   = bus.in_data;
                        w_state_next = Replace;
                    end
                    NOP: ;
                endcase
            end
            Push: begin
                w_we         = 1'b1;
                w_count_next = r_count + C_ONE;
                w_top_next   = r_buf;
                w_state_next = Idle;
            end
            Replace: begin
                w_we         = 1'b1;
                w_waddr      = w_count_m1[ADDR_BITS-1:0];
                w_top_next   = r_buf;
                w_state_next = Idle;
            end
            Pop: begin
                w_count_next = w_count_m1;
                if (w_count_m1 == '0) begin
                    w_top_next   = '0;
                    w_state_next = Idle;
                end else begin
                    w_state_next = Refresh;
                end
            end
            Refresh: begin
                // count already points past the new top, so count-1 addresses it
                w_top_next   = w_rdata;
                w_state_next = Idle;
            end
            default: w_state_next = Idle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= Idle;
            r_count <= '0;
            r_buf   <= '0;
            r_top   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_buf   <= w_buf_next;
            r_top   <= w_top_next;
        end
    end

`ifdef LIFO_STACK_ERR_EN
    logic r_err;
    logic w_illegal;

    assign w_illegal = (r_state == Idle) &&
                       (((bus.in_cmd == PUSH)    && w_full)  ||
                        ((bus.in_cmd == POP)     && w_empty) ||
                        ((bus.in_cmd == REPLACE) && w_empty));

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.out_top   = r_top;
    assign bus.out_count = r_count;
    assign bus.out_empty = w_empty;
    assign bus.out_full  = w_full;
    assign bus.out_ready = (r_state == Idle);

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios then random commands
// against a queue-based model of the stack.
module tb_lifo_stack;
    import lifo_pkg::*;

    localparam int AB    = 3;
    localparam int WB    = 8;
    localparam int DEPTH = 2**AB;
`ifdef LIFO_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    lifo_stack_if #(.ADDR_BITS(AB), .WORD_BITS(WB)) bus ();

    lifo_stack #(.ADDR_BITS(AB), .WORD_BITS(WB)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [WB-1:0] model_q[$];
    bit          model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [WB-1:0] exp_top;
        exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
        check({tag, ":top"},   32'(bus.out_top),   32'(exp_top));
        check({tag, ":count"}, 32'(bus.out_count), 32'(model_q.size()));
        check({tag, ":empty"}, 32'(bus.out_empty), 32'(model_q.size() == 0));
        check({tag, ":full"},  32'(bus.out_full),  32'(model_q.size() == DEPTH));
        check({tag, ":ready"}, 32'(bus.out_ready), 32'd1);
        check({tag, ":err"},   32'(bus.out_err),   32'(model_err & ERR_EN));
    endtask

    // Called and returns at a falling edge; issues one command and checks the result.
    task automatic run_cmd(input t_lifo_cmd cmd, input logic [WB-1:0] data, input string tag);
        int guard;
        int busy;
        int exp_busy;
        guard = 0;
        while (bus.out_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check({tag, ":ready_wait"}, 32'd0, 32'd1);
        bus.in_cmd  = cmd;
        bus.in_data = data;
        @(posedge clk);
        #1;
        bus.in_cmd  = NOP;
        bus.in_data = WB'($urandom);

        exp_busy = 0;
        case (cmd)
            PUSH: if (model_q.size() < DEPTH) begin
                model_q.push_back(data);
                exp_busy = 1;
            end else model_err = 1'b1;
            POP: if (model_q.size() > 0) begin
                void'(model_q.pop_back());
                exp_busy = (model_q.size() == 0) ? 1 : 2;
            end else model_err = 1'b1;
            REPLACE: if (model_q.size() > 0) begin
                model_q[model_q.size()-1] = data;
                exp_busy = 1;
            end else model_err = 1'b1;
            default: ;
        endcase

        busy = 0;
        @(negedge clk);
        while (bus.out_ready !== 1'b1 && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        check({tag, ":busy"}, 32'(busy), 32'(exp_busy));
        check_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_cmd  = NOP;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_err = 1'b0;
    endtask

    initial begin
        t_lifo_cmd     cmd;
        logic [WB-1:0] prev_top;

        do_reset();
        check_state("reset");

        run_cmd(PUSH, 8'h11, "push11");
        run_cmd(PUSH, 8'h22, "push22");
        run_cmd(PUSH, 8'h33, "push33");
        run_cmd(POP,  8'h00, "pop_to_22");
        run_cmd(REPLACE, 8'hAA, "replace_aa");
        run_cmd(POP,  8'h00, "pop_to_11");

        for (int i = 0; i < DEPTH - 1; i++) run_cmd(PUSH, 8'(8'h40 + i), "fill");
        check("full_flag", 32'(bus.out_full), 32'd1);
        prev_top = bus.out_top;
        run_cmd(PUSH, 8'hEE, "push_when_full");
        check("full_top_kept", 32'(bus.out_top), 32'(prev_top));
        for (int i = 0; i < DEPTH; i++) run_cmd(POP, 8'h00, "drain");
        run_cmd(POP, 8'h00, "pop_when_empty");
        run_cmd(REPLACE, 8'h77, "replace_when_empty");
        run_cmd(PUSH, 8'h01, "push_after_err");

        // Reset during the Refresh cycle of a pop from count 4.
        do_reset();
        for (int i = 0; i < 4; i++) run_cmd(PUSH, 8'(8'hA0 + i), "pre_rst");
        bus.in_cmd = POP;
        @(posedge clk);
        #1;
        bus.in_cmd = NOP;
        @(posedge clk);
        #1;
        check("refresh:count_first", 32'(bus.out_count), 32'd3);
        check("refresh:top_held",    32'(bus.out_top),   32'hA3);
        check("refresh:busy",        32'(bus.out_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        check_state("rst_in_refresh");
        run_cmd(PUSH, 8'h5C, "push_5c");

        // Random phase: push-biased first half, pop-biased second half.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (i < 150) cmd = (r < 5) ? PUSH : (r < 7) ? POP : (r < 9) ? REPLACE : NOP;
            else         cmd = (r < 5) ? POP  : (r < 7) ? PUSH : (r < 9) ? REPLACE : NOP;
            run_cmd(cmd, WB'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
